// File: rtl/picorv_pcpi_divx.sv
// PCPI divide/remainder coprocessor: DIV/DIVU/REM/REMU plus RV64 word forms.
// Restoring shift-subtract divider retiring STEPS quotient bits per RUN cycle.
module picorv_pcpi_divx #(
  parameter int XLEN     = 64,
  parameter int STEPS    = 1,
  parameter int ENABLE_W = 1
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic            pcpi_valid,
  input  logic [31:0]     pcpi_insn,
  input  logic [XLEN-1:0] pcpi_rs1,
  input  logic [XLEN-1:0] pcpi_rs2,
  output logic            pcpi_wr,
  output logic [XLEN-1:0] pcpi_rd,
  output logic            pcpi_wait,
  output logic            pcpi_ready
);

  localparam int DW = 2*XLEN-1;
  localparam int CW = $clog2(XLEN/STEPS+1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  function automatic logic [XLEN-1:0] sext32(input logic [XLEN-1:0] v);
    logic signed [31:0] lo;
    lo = v[31:0];
    return XLEN'(lo);
  endfunction

  function automatic logic [XLEN-1:0] apply_sign(input logic [XLEN-1:0] v, input logic neg);
    return neg ? -v : v;
  endfunction

  state_t          state_q, state_d;
  logic            is_rem_q, is_rem_d, word_q, word_d, neg_q, neg_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [XLEN:0]   rem_q, rem_d;
  logic [DW-1:0]   div_q, div_d;
  logic [XLEN-1:0] quot_q, quot_d;
  logic            wr_q, wr_d, ready_q, ready_d;
  logic [XLEN-1:0] rd_q, rd_d;

  logic            md_op, dec_full, dec_word, dec_hit, w32, is_signed, is_rem;
  logic            neg_a, neg_b, b_zero, a_min, b_m1, ovf;
  logic [XLEN-1:0] op_a, op_b, abs_a, abs_b;
  logic            unused_insn;

  assign md_op     = (pcpi_insn[31:25] == 7'b0000001) && pcpi_insn[14];
  assign dec_full  = md_op && (pcpi_insn[6:0] == 7'b0110011);
  assign dec_word  = (XLEN == 64) && (ENABLE_W != 0) && md_op && (pcpi_insn[6:0] == 7'b0111011);
  assign dec_hit   = dec_full || dec_word;
  assign w32       = dec_word || (XLEN == 32);
  assign is_signed = !pcpi_insn[12];
  assign is_rem    = pcpi_insn[13];
  assign unused_insn = ^{pcpi_insn[24:15], pcpi_insn[11:7]};

  // Word ops divide only the low halves; unsigned word operands are zero-extended
  always_comb begin
    op_a = pcpi_rs1;
    op_b = pcpi_rs2;
    if (dec_word) begin
      op_a = is_signed ? sext32(pcpi_rs1) : XLEN'(pcpi_rs1[31:0]);
      op_b = is_signed ? sext32(pcpi_rs2) : XLEN'(pcpi_rs2[31:0]);
    end
  end

  assign neg_a  = is_signed && (w32 ? pcpi_rs1[31] : pcpi_rs1[XLEN-1]);
  assign neg_b  = is_signed && (w32 ? pcpi_rs2[31] : pcpi_rs2[XLEN-1]);
  assign abs_a  = neg_a ? -op_a : op_a;
  assign abs_b  = neg_b ? -op_b : op_b;
  assign b_zero = w32 ? (pcpi_rs2[31:0] == 32'd0) : (pcpi_rs2 == '0);
  assign a_min  = w32 ? (pcpi_rs1[31:0] == 32'h8000_0000)
                      : (pcpi_rs1 == {1'b1, {(XLEN-1){1'b0}}});
  assign b_m1   = w32 ? (&pcpi_rs2[31:0]) : (&pcpi_rs2);
  assign ovf    = is_signed && a_min && b_m1;

  always_comb begin
    logic [XLEN:0]   r;
    logic [DW-1:0]   d;
    logic [XLEN-1:0] q;
    logic [XLEN-1:0] res;
    logic            ge;
    state_d  = state_q;
    is_rem_d = is_rem_q;
    word_d   = word_q;
    neg_d    = neg_q;
    cnt_d    = cnt_q;
    rem_d    = rem_q;
    div_d    = div_q;
    quot_d   = quot_q;
    wr_d     = 1'b0;
    ready_d  = 1'b0;
    rd_d     = '0;
    res      = '0;
    ge       = 1'b0;
    r        = rem_q;
    d        = div_q;
    q        = quot_q;
    for (int s = 0; s < STEPS; s++) begin
      ge = (d <= DW'(r));
      if (ge) r = r - d[XLEN:0];
      q = {q[XLEN-2:0], ge};
      d = d >> 1;
    end
    case (state_q)
      S_IDLE: begin
        if (pcpi_valid && !pcpi_ready && dec_hit) begin
          is_rem_d = is_rem;
          word_d   = dec_word;
          neg_d    = is_signed && (is_rem ? neg_a : (neg_a ^ neg_b));
          // Special cases preload the final unsigned result and skip RUN
          if (b_zero) begin
            quot_d  = '1;
            rem_d   = {1'b0, pcpi_rs1};
            neg_d   = 1'b0;
            state_d = S_DONE;
          end else if (ovf) begin
            quot_d  = pcpi_rs1;
            rem_d   = '0;
            neg_d   = 1'b0;
            state_d = S_DONE;
          end else begin
            quot_d  = '0;
            rem_d   = {1'b0, abs_a};
            div_d   = w32 ? (DW'(abs_b) << 31) : (DW'(abs_b) << (XLEN-1));
            cnt_d   = w32 ? CW'(32/STEPS) : CW'(XLEN/STEPS);
            state_d = S_RUN;
          end
        end
      end
      S_RUN: begin
        if (!pcpi_valid) begin
          state_d = S_IDLE;
        end else begin
          rem_d  = r;
          div_d  = d;
          quot_d = q;
          cnt_d  = cnt_q - CW'(1);
          if (cnt_q == CW'(1)) state_d = S_DONE;
        end
      end
      S_DONE: begin
        res = apply_sign(is_rem_q ? rem_q[XLEN-1:0] : quot_q, neg_q);
        if (word_q) res = sext32(res);
        rd_d    = res;
        wr_d    = 1'b1;
        ready_d = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= S_IDLE;
      wr_q    <= 1'b0;
      ready_q <= 1'b0;
      rd_q    <= '0;
    end else begin
      state_q <= state_d;
      wr_q    <= wr_d;
      ready_q <= ready_d;
      rd_q    <= rd_d;
    end
  end

  always_ff @(posedge clk) begin
    is_rem_q <= is_rem_d;
    word_q   <= word_d;
    neg_q    <= neg_d;
    cnt_q    <= cnt_d;
    rem_q    <= rem_d;
    div_q    <= div_d;
    quot_q   <= quot_d;
  end

  assign pcpi_wait  = (state_q != S_IDLE);
  assign pcpi_wr    = wr_q;
  assign pcpi_ready = ready_q;
  assign pcpi_rd    = rd_q;

endmodule

// File: doc/picorv_pcpi_divx.md
# picorv_pcpi_divx

Multi-width, multi-step PCPI divide/remainder coprocessor for the picorv core, replacing the fixed 32-bit restoring divider. It sits beside the PCPI multiplier on the core's PCPI bus. It executes RV32M/RV64M DIV/DIVU/REM/REMU plus the RV64 word forms DIVW/DIVUW/REMW/REMUW, with full RISC-V divide-by-zero and signed-overflow semantics. Throughput is configurable by retiring 1, 2 or 4 quotient bits per cycle.

## Interface
- XLEN, 64: datapath width; legal values 32 or 64.
- STEPS, 1: quotient bits per RUN cycle; legal values 1, 2, 4.
- ENABLE_W, 1: decode OP-32 word forms; ignored when XLEN=32.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- resetn  in  1  reset, synchronous, active-low.
- pcpi_valid  in  1  core presents an instruction; held until pcpi_ready or abort.
- pcpi_insn  in  32  instruction word.
- pcpi_rs1  in  XLEN  dividend operand.
- pcpi_rs2  in  XLEN  divisor operand.
- pcpi_wr  out  1  result write-back strobe; coincident with pcpi_ready.
- pcpi_rd  out  XLEN  result; 0 whenever pcpi_ready=0.
- pcpi_wait  out  1  instruction accepted, result pending.
- pcpi_ready  out  1  one-cycle completion pulse.

## Operation
- Decode requires insn[31:25]=0000001 and funct3[2]=1.
  - Opcode 0110011 gives the full-width op.
  - Opcode 0111011 gives the word op, only when XLEN=64 and ENABLE_W=1.
  - funct3 100=DIV, 101=DIVU, 110=REM, 111=REMU. Anything else is ignored.
- Effective width W: 32 for word ops or XLEN=32, else XLEN.
  - Word ops use rs1[31:0] and rs2[31:0].
  - Every word-op result, including DIVUW/REMUW, is sign-extended from bit 31 to XLEN.
- State machine: IDLE, RUN, DONE.
  - IDLE → RUN on a decoded instruction with pcpi_valid=1 and pcpi_ready=0. This edge latches the op, abs(operands) for signed ops, the output sign and count=W/STEPS.
  - IDLE → DONE instead, with a preset result, in two special cases:
  - Divisor=0: quotient = all ones (W bits, then extended); remainder = dividend.
  - Signed overflow (dividend = −2^(W−1), divisor = −1): quotient = dividend; remainder = 0.
  - RUN performs STEPS restoring shift-subtract steps per cycle and decrements count. It moves to DONE when count reaches 0.
  - DONE applies the sign (DIV: sign(rs1) xor sign(rs2); REM: sign of dividend). It registers pcpi_rd, pcpi_wr=1 and pcpi_ready=1, then returns to IDLE.
- Abort: pcpi_valid=0 in any RUN cycle returns the block to IDLE. pcpi_wait drops the next cycle and no ready pulse is produced.
- An instruction is never re-accepted in the cycle pcpi_ready=1, even though pcpi_valid is still high.
- Internal remainder/divisor registers are W+1 and 2W−1 bits at XLEN width. No truncation occurs for W=64.

## Timing
- Reset (resetn=0 at an edge): state=IDLE; pcpi_wr, pcpi_wait and pcpi_ready = 0; pcpi_rd=0.
  - Reset mid-operation discards the operation with no ready pulse.
- Acceptance: the instruction is sampled in cycle N. pcpi_wait=1 from cycle N+1 through the cycle before pcpi_ready.
- Latency, normal case: pcpi_ready=1 in cycle N+2+W/STEPS.
  - STEPS=1: 66 cycles for 64-bit, 34 for 32-bit.
  - STEPS=4: 18 cycles for 64-bit.
- Latency, special case (divisor=0 or overflow): pcpi_ready=1 in cycle N+2.
- pcpi_ready and pcpi_wr are exactly one cycle wide. pcpi_wait=0 in that same cycle.
- Earliest next acceptance is cycle N'+1, where N' is the ready cycle.
- Non-matching instructions never assert any output.

## Test plan
- XLEN=64, STEPS=1, DIV rs1=100, rs2=−7 → pcpi_rd=−14 (0xFFFFFFFFFFFFFFF2) exactly 66 cycles after acceptance. REM on the same operands → 2. REMU with rs1=100, rs2=7 → 2.
- DIVU with rs2=0, rs1=5 → 0xFFFFFFFFFFFFFFFF, and REMU → 5, each in cycle N+2. DIV with rs1=0x8000000000000000, rs2=−1 → 0x8000000000000000, and REM → 0.
- DIVW with rs1=0x1234567880000000, rs2=0xFFFFFFFFFFFFFFFF → 0xFFFFFFFF80000000. DIVUW with rs1=0x00000001FFFFFFFF, rs2=1 → 0xFFFFFFFFFFFFFFFF after 34 cycles. REMW with rs1=−9, rs2=4 → −1.
- STEPS=2 and STEPS=4 sweep of 10k random operand/op pairs against a reference model:
  - All results match the model.
  - Latency equals N+2+W/STEPS on every operation.
- Drop pcpi_valid at RUN cycle 5, then issue DIVU 10/3 → no ready pulse for the first op; second op returns 3. Assert resetn=0 mid-RUN → all outputs 0 next cycle.
- MUL (funct3=000) and ADD (funct7=0) held valid 100 cycles → pcpi_wait and pcpi_ready stay 0. XLEN=32 with DIVW opcode → ignored.
